mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_pkg.sv | 11 +
 rtl/register.sv | 23 ++
 rtl/mem_stage.sv | 129 ++++++++++++
 tb/tb_mem_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: FSM state encoding and default widths.
package mem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N       = 32;
  localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/register.sv
// Generic N-bit register with synchronous active-high clear and write enable.
// One-cycle latency; holds its value whenever wen is low.
module register
  import mem_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wen,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (wen) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage bus master: IDLE -> REQ (until ack) -> DONE, 3 cycles minimum per access.
// Stalls the pipeline while an aligned access is outstanding; MEM_TIMEOUT_EN adds a wait-cycle bound.
module mem_stage
  import mem_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         memr_M,
  input  logic         memw_M,
  input  logic [N-1:0] ALUrslt_M,
  input  logic [N-1:0] writedata_M,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
  output logic [N-1:0] readdata_M,
  output logic         stall_M,
  output logic         misalign_M,
  output logic         bus_err_M
);

  state_t       state;
  logic [N-1:0] addr_q;
  logic [N-1:0] wdata_q;
  logic         we_q;
  logic         req_q;
  logic         access;
  logic         aligned;
  logic         start;
  logic         rd_ack;
  logic         timeout;
  logic         rd_wen;
  logic [N-1:0] rd_d;

  assign access     = memr_M | memw_M;
  assign aligned    = (ALUrslt_M[1:0] == 2'b00);
  assign start      = (state == IDLE) && access && aligned;
  assign stall_M    = start || (state == REQ);
  assign misalign_M = (state == IDLE) && access && !aligned;

  assign mem_req    = req_q;
  assign mem_we     = req_q & we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

  // A simultaneous load+store latches we_q=1, so the ack never counts as a read.
  assign rd_ack     = (state == REQ) && mem_ack && !we_q;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;
  logic          berr_q;

  assign timeout   = (state == REQ) && !mem_ack && (wait_cnt == CW'(TIMEOUT - 1));
  assign rd_wen    = rd_ack | timeout;
  assign rd_d      = timeout ? '0 : mem_rdata;
  assign bus_err_M = berr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      berr_q   <= 1'b0;
    end else begin
      berr_q <= timeout;
      if (start) begin
        wait_cnt <= '0;
      end else if ((state == REQ) && !mem_ack) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`else
  assign timeout   = 1'b0;
  assign rd_wen    = rd_ack;
  assign rd_d      = mem_rdata;
  // Constant 0: without the timeout build there is no error source.
  assign bus_err_M = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_q  <= ALUrslt_M;
            wdata_q <= writedata_M;
            we_q    <= memw_M;
            req_q   <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (mem_ack || timeout) begin
            req_q <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          req_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  register #(.N(N)) u_readdata (
    .clk (clk),
    .rst (rst),
    .wen (rd_wen),
    .d   (rd_d),
    .q   (readdata_M)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: per-cycle expectations built from access-level rules.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        memr_M, memw_M, mem_ack;
  logic [31:0] ALUrslt_M, writedata_M, mem_rdata;
  logic        mem_req, mem_we, stall_M, misalign_M, bus_err_M;
  logic [31:0] mem_addr, mem_wdata, readdata_M;

  always #5 clk = ~clk;

  mem_stage #(.N(32), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .memr_M      (memr_M),
    .memw_M      (memw_M),
    .ALUrslt_M   (ALUrslt_M),
    .writedata_M (writedata_M),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .readdata_M  (readdata_M),
    .stall_M     (stall_M),
    .misalign_M  (misalign_M),
    .bus_err_M   (bus_err_M)
  );

  typedef struct {
    logic        rst, memr, memw, ack;
    logic [31:0] addr, wdata, rdata;
    bit          chk, chk_we;
    logic        e_req, e_we, e_stall, e_mis, e_berr;
    logic [31:0] e_addr, e_wdata, e_rd;
    int          tag;
  } cyc_t;

  cyc_t        q[$];
  logic [31:0] model_rd;
  int          vectors = 0;
  int          errs = 0;
  int          st_cnt[8];
  int          rq_cnt[8];
  logic [31:0] rd_last[8];

  function automatic cyc_t blank();
    cyc_t c;
    c.rst = 0; c.memr = 0; c.memw = 0; c.ack = 0;
    c.addr = 0; c.wdata = 0; c.rdata = 32'h0BAD_0BAD;
    c.chk = 1; c.chk_we = 0;
    c.e_req = 0; c.e_we = 0; c.e_stall = 0; c.e_mis = 0; c.e_berr = 0;
    c.e_addr = 0; c.e_wdata = 0; c.e_rd = model_rd; c.tag = 0;
    return c;
  endfunction

  task automatic idle(input int n, input logic ack);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank();
      c.ack = ack;
      c.rdata = 32'h5A5A_0000 + i;
      q.push_back(c);
    end
  endtask

  // One instruction: a misaligned one occupies a single cycle; an aligned one
  // spends 1 IDLE cycle, waits+1 REQ cycles (ack on the last) and 1 DONE cycle.
  task automatic access(input int tag, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int waits, input logic [31:0] rd);
    cyc_t c;
    c = blank();
    c.tag = tag; c.memr = r; c.memw = w; c.addr = a; c.wdata = d;
    if (a[1:0] != 2'b00) begin
      c.e_mis = 1;
      q.push_back(c);
      return;
    end
    c.e_stall = 1;
    q.push_back(c);
    for (int i = 0; i <= waits; i++) begin
      c.e_req = 1; c.chk_we = 1; c.e_we = w; c.e_addr = a; c.e_wdata = d;
      c.ack = (i == waits);
      c.rdata = c.ack ? rd : 32'hEEEE_0000 + i;
      q.push_back(c);
    end
    if (!w) model_rd = rd;
    c.ack = 0; c.e_req = 0; c.chk_we = 0; c.e_stall = 0; c.e_rd = model_rd;
    q.push_back(c);
  endtask

  task automatic reset_mid_req(input int tag);
    cyc_t c;
    c = blank();
    c.tag = tag; c.memr = 1; c.addr = 32'h40;
    c.e_stall = 1;
    q.push_back(c);
    c.e_req = 1; c.chk_we = 1; c.e_we = 0; c.e_addr = 32'h40; c.e_wdata = 0;
    q.push_back(c);
    c.rst = 1; c.memr = 0;
    q.push_back(c);
    model_rd = 0;
    c = blank();
    c.tag = tag; c.ack = 1; c.rdata = 32'h7777_7777; c.chk_we = 1;
    q.push_back(c);
    c.ack = 0;
    q.push_back(c);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic timeout_load(input int tag);
    cyc_t c;
    c = blank();
    c.tag = tag; c.memr = 1; c.addr = 32'h80;
    c.e_stall = 1;
    q.push_back(c);
    for (int i = 0; i < 4; i++) begin
      c.e_req = 1; c.chk_we = 1; c.e_addr = 32'h80; c.e_wdata = 0;
      q.push_back(c);
    end
    model_rd = 0;
    c.e_req = 0; c.chk_we = 0; c.e_stall = 0; c.e_berr = 1; c.e_rd = 0;
    q.push_back(c);
    c = blank();
    c.tag = tag;
    q.push_back(c);
  endtask
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    cyc_t c;
    for (int i = 0; i < 8; i++) begin
      st_cnt[i] = 0; rq_cnt[i] = 0; rd_last[i] = 0;
    end
    model_rd = 0;
    rst = 1; memr_M = 0; memw_M = 0; mem_ack = 0;
    ALUrslt_M = 0; writedata_M = 0; mem_rdata = 0;

    c = blank(); c.rst = 1; c.chk = 0; q.push_back(c);
    c = blank(); c.rst = 1; c.chk_we = 1; q.push_back(c);
    idle(2, 1'b1);
    access(1, 1, 0, 32'h100, 32'h0, 2, 32'hDEADBEEF);
    idle(1, 1'b0);
    access(2, 0, 1, 32'h20, 32'h12345678, 0, 32'hAAAAAAAA);
    access(3, 1, 0, 32'h103, 32'h0, 0, 32'h0);
    access(3, 0, 1, 32'h22, 32'hFFFF, 0, 32'h0);
    idle(1, 1'b1);
    access(4, 1, 1, 32'h8, 32'hCAFEF00D, 1, 32'h55555555);
    access(5, 1, 0, 32'h0, 32'h0, 0, 32'h11111111);
    access(5, 1, 0, 32'h4, 32'h0, 0, 32'h22222222);
`ifdef MEM_TIMEOUT_EN
    timeout_load(7);
`endif
    reset_mid_req(6);
    idle(2, 1'b0);

    while (q.size() > 0) begin
      c = q.pop_front();
      @(posedge clk);
      #1;
      rst = c.rst; memr_M = c.memr; memw_M = c.memw; mem_ack = c.ack;
      ALUrslt_M = c.addr; writedata_M = c.wdata; mem_rdata = c.rdata;
      @(negedge clk);
      if (c.chk) begin
        chk("mem_req", {31'b0, mem_req}, {31'b0, c.e_req});
        chk("stall_M", {31'b0, stall_M}, {31'b0, c.e_stall});
        chk("misalign_M", {31'b0, misalign_M}, {31'b0, c.e_mis});
        chk("bus_err_M", {31'b0, bus_err_M}, {31'b0, c.e_berr});
        chk("readdata_M", readdata_M, c.e_rd);
        if (c.chk_we) chk("mem_we", {31'b0, mem_we}, {31'b0, c.e_we});
        if (c.e_req) begin
          chk("mem_addr", mem_addr, c.e_addr);
          if (c.e_we) chk("mem_wdata", mem_wdata, c.e_wdata);
        end
        st_cnt[c.tag] += int'(stall_M);
        rq_cnt[c.tag] += int'(mem_req);
        rd_last[c.tag] = readdata_M;
      end
    end

    chk("load_stall_cycles", st_cnt[1], 4);
    chk("load_req_cycles", rq_cnt[1], 3);
    chk("load_data", rd_last[1], 32'hDEADBEEF);
    chk("store_stall_cycles", st_cnt[2], 2);
    chk("store_req_cycles", rq_cnt[2], 1);
    chk("store_keeps_data", rd_last[2], 32'hDEADBEEF);
    chk("misalign_stall_cycles", st_cnt[3], 0);
    chk("misalign_req_cycles", rq_cnt[3], 0);
    chk("ldst_keeps_data", rd_last[4], 32'hDEADBEEF);
    chk("b2b_stall_cycles", st_cnt[5], 4);
    chk("b2b_req_cycles", rq_cnt[5], 2);
    chk("b2b_last_data", rd_last[5], 32'h22222222);
    chk("reset_clears_data", rd_last[6], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
